// File: rtl/upcnt_arb.sv
// upcnt_arb: round-robin arbiter sharing one saturating decade up-counter among four requesters.
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   req      in   [3:0] per-requester job request, held until done or dropped to abort
//   tick     in   [3:0] per-requester count strobe; only the granted bit is used
//   cnt_val  in   [3:0] value read back from the shared counter
//   gnt      out  [3:0] registered one-hot grant
//   done     out  [3:0] registered one-cycle completion pulse
//   busy     out  high whenever a job is in progress
//   cnt_en   out  combinational counter enable
//   cnt_clr  out  flop-driven counter clear pulse, ORed with reset at the counter
module upcnt_arb #(
    parameter logic [3:0] LIMIT = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] tick,
    input  logic [3:0] cnt_val,
    output logic [3:0] gnt,
    output logic [3:0] done,
    output logic       busy,
    output logic       cnt_en,
    output logic       cnt_clr
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d, done_q, done_d;
    logic [1:0] g_q, g_d, ptr_q, ptr_d, pick;
    logic       clr_q, clr_d, found, req_g, abort;
    // first requester at or after the pointer, wrapping 3 -> 0
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[ptr_q + 2'(i)]) begin
                found = 1'b1;
                pick  = ptr_q + 2'(i);
            end
        end
    end
    assign req_g = req[g_q];
    // a dropped request while holding the counter ends the job without a done pulse
    assign abort = ((state_q == CLEAR) || (state_q == RUN)) && !req_g;
    // enable stops at LIMIT so the counter never overshoots, and is masked in the abort cycle
    assign cnt_en = (state_q == RUN) && req_g && tick[g_q] && (cnt_val != LIMIT);
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        done_d  = 4'b0;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = CLEAR;
                    g_d     = pick;
                    gnt_d   = 4'b1 << pick;
                    clr_d   = 1'b1;
                end
            end
            CLEAR: state_d = RUN;
            RUN: begin
                if (cnt_val == LIMIT) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 4'b0;
                ptr_d   = g_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            gnt_d   = 4'b0;
            done_d  = 4'b0;
            ptr_d   = g_q + 2'd1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0;
            done_q  <= 4'b0;
            g_q     <= 2'd0;
            ptr_q   <= 2'd0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            clr_q   <= clr_d;
        end
    end
    assign gnt     = gnt_q;
    assign done    = done_q;
    assign cnt_clr = clr_q;
    assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_upcnt_arb.sv
// tb_upcnt_arb: directed bench for upcnt_arb with LIMIT=9 and LIMIT=3 instances,
// each driving its own saturating decade counter whose reset is reset | cnt_clr.
module tb_upcnt_arb;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req9, tick9, gnt9, done9, val9;
    logic [3:0] req3, tick3, gnt3, done3, val3;
    logic       busy9, en9, clr9, busy3, en3, clr3;
    logic       rst9, rst3;
    int         checks = 0;
    int         errors = 0;
    always #5 clk = ~clk;
    upcnt_arb u9 (
        .clk(clk), .reset(reset), .req(req9), .tick(tick9), .cnt_val(val9),
        .gnt(gnt9), .done(done9), .busy(busy9), .cnt_en(en9), .cnt_clr(clr9)
    );
    upcnt_arb #(.LIMIT(4'd3)) u3 (
        .clk(clk), .reset(reset), .req(req3), .tick(tick3), .cnt_val(val3),
        .gnt(gnt3), .done(done3), .busy(busy3), .cnt_en(en3), .cnt_clr(clr3)
    );
    assign rst9 = reset | clr9;
    assign rst3 = reset | clr3;
    always @(posedge clk or posedge rst9)
        if (rst9) val9 <= 4'd0;
        else if (en9 && val9 != 4'd9) val9 <= val9 + 4'd1;
    always @(posedge clk or posedge rst3)
        if (rst3) val3 <= 4'd0;
        else if (en3 && val3 != 4'd9) val3 <= val3 + 4'd1;
    typedef struct {
        logic [3:0] req, tick, gnt, done;
        logic       busy, en, clr;
        logic [3:0] val;
    } vec_t;
    vec_t t9[15];
    vec_t t3[11];
    function automatic vec_t mk(input logic [3:0] rq, tk, g, d, input logic b, e, c, input logic [3:0] v);
        vec_t r;
        r.req = rq; r.tick = tk; r.gnt = g; r.done = d;
        r.busy = b; r.en = e; r.clr = c; r.val = v;
        return r;
    endfunction
    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        reset = 1'b1;
        req9 = 4'b0; tick9 = 4'b0; req3 = 4'b0; tick3 = 4'b0;
        #1;
        chk("rst.gnt", gnt9, 4'b0);
        chk("rst.done", done9, 4'b0);
        chk("rst.busy", 4'(busy9), 4'b0);
        chk("rst.clr", 4'(clr9), 4'b0);
        chk("rst.en", 4'(en9), 4'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask
    // row = inputs applied for one cycle and the outputs expected during that cycle
    task automatic apply(input bit s3, input vec_t v, input int idx);
        string p;
        p = $sformatf("%s[%0d]", s3 ? "lim3" : "lim9", idx);
        if (s3) begin req3 = v.req; tick3 = v.tick; end
        else begin req9 = v.req; tick9 = v.tick; end
        #1;
        chk({p, ".gnt"}, s3 ? gnt3 : gnt9, v.gnt);
        chk({p, ".done"}, s3 ? done3 : done9, v.done);
        chk({p, ".busy"}, 4'(s3 ? busy3 : busy9), 4'(v.busy));
        chk({p, ".en"}, 4'(s3 ? en3 : en9), 4'(v.en));
        chk({p, ".clr"}, 4'(s3 ? clr3 : clr9), 4'(v.clr));
        chk({p, ".val"}, s3 ? val3 : val9, v.val);
        step();
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        int order[5];
        int n, last;
        logic [3:0] prev;
        order = '{0, 1, 2, 3, 0};
        t9[0] = mk(4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 4'd0);
        t9[1] = mk(4'b0100, 4'b0100, 4'b0100, 4'b0000, 1, 0, 1, 4'd0);
        for (int m = 0; m <= 9; m++)
            t9[2 + m] = mk(4'b0100, 4'b0100, 4'b0100, 4'b0000, 1, m != 9, 0, 4'(m));
        t9[12] = mk(4'b0000, 4'b0100, 4'b0100, 4'b0100, 1, 0, 0, 4'd9);
        t9[13] = mk(4'b0000, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 4'd9);
        t9[14] = mk(4'b0000, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 4'd9);
        t3[0]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'd0);
        t3[1]  = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1, 0, 1, 4'd0);
        t3[2]  = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1, 1, 0, 4'd0);
        t3[3]  = mk(4'b0001, 4'b1110, 4'b0001, 4'b0000, 1, 0, 0, 4'd1);
        t3[4]  = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1, 1, 0, 4'd1);
        t3[5]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 4'd2);
        t3[6]  = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1, 1, 0, 4'd2);
        t3[7]  = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1, 0, 0, 4'd3);
        t3[8]  = mk(4'b0000, 4'b0001, 4'b0001, 4'b0001, 1, 0, 0, 4'd3);
        t3[9]  = mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 4'd3);
        t3[10] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'd3);
        do_reset();
        for (int i = 0; i < 15; i++) apply(1'b0, t9[i], i);
        for (int i = 0; i < 11; i++) apply(1'b1, t3[i], i);
        // all four requesting: strict rotation, 13-cycle jobs, one-hot grants
        do_reset();
        req9 = 4'b1111; tick9 = 4'b1111;
        n = 0; last = 0; prev = 4'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            chk("rr.gnt_onehot", 4'($countones(gnt9) <= 1), 4'd1);
            chk("rr.done_onehot", 4'($countones(done9) <= 1), 4'd1);
            if (gnt9 != 4'b0 && prev == 4'b0) begin
                if (n < 5) chk($sformatf("rr.order[%0d]", n), gnt9, 4'(1 << order[n]));
                if (n > 0) chk($sformatf("rr.period[%0d]", n), 4'(c - last), 4'd13);
                last = c;
                n++;
            end
            prev = gnt9;
            @(posedge clk);
            #1;
        end
        chk("rr.grants", 4'(n), 4'd5);
        // move the pointer to 2 with a job for requester 1
        do_reset();
        req9 = 4'b0010; tick9 = 4'b1111;
        for (int i = 0; i < 40 && done9 == 4'b0; i++) step();
        chk("ptr2.done", done9, 4'b0010);
        req9 = 4'b0000;
        step();
        chk("ptr2.idle", 4'(busy9), 4'b0);
        // wrap-around search from 2 finds 0 before 1
        req9 = 4'b0011;
        for (int i = 0; i < 40 && gnt9 == 4'b0; i++) step();
        chk("wrap.first", gnt9, 4'b0001);
        for (int i = 0; i < 40 && done9 == 4'b0; i++) step();
        chk("wrap.done0", done9, 4'b0001);
        req9 = 4'b0010;
        step();
        chk("wrap.gap", gnt9, 4'b0000);
        for (int i = 0; i < 40 && gnt9 == 4'b0; i++) step();
        chk("wrap.second", gnt9, 4'b0010);
        // abort requester 1 at count 5
        for (int i = 0; i < 20 && val9 != 4'd5; i++) step();
        chk("abort.val5", val9, 4'd5);
        req9 = 4'b0101;
        #1;
        chk("abort.en", 4'(en9), 4'b0);
        chk("abort.gnt_held", gnt9, 4'b0010);
        step();
        chk("abort.gnt", gnt9, 4'b0000);
        chk("abort.busy", 4'(busy9), 4'b0);
        chk("abort.done", done9, 4'b0000);
        chk("abort.val_kept", val9, 4'd5);
        step();
        chk("abort.next", gnt9, 4'b0100);
        chk("abort.clr", 4'(clr9), 4'b1);
        // reset mid-run at count 4
        for (int i = 0; i < 20 && val9 != 4'd4; i++) step();
        chk("mrst.val4", val9, 4'd4);
        reset = 1'b1;
        #1;
        chk("mrst.gnt", gnt9, 4'b0000);
        chk("mrst.done", done9, 4'b0000);
        chk("mrst.busy", 4'(busy9), 4'b0);
        chk("mrst.clr", 4'(clr9), 4'b0);
        chk("mrst.en", 4'(en9), 4'b0);
        chk("mrst.val", val9, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        req9 = 4'b1001;
        step();
        chk("mrst.ptr0", gnt9, 4'b0001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
